// File: rtl/vga_capture_if.sv
// Video-input bus for vga_capture: sampled sync/pixel stream in, frame-memory write port and
// status out.
interface vga_capture_if;
  logic        pix_en;
  logic        hsync;
  logic        vsync;
  logic [23:0] din;
  logic [18:0] addr;
  logic [23:0] data;
  logic        wren;
  logic        frame_done;
  logic        locked;
  logic        err;

  modport master (
    output pix_en, hsync, vsync, din,
    input  addr, data, wren, frame_done, locked, err
  );

  modport slave (
    input  pix_en, hsync, vsync, din,
    output addr, data, wren, frame_done, locked, err
  );
endinterface

// File: rtl/vga_capture.sv
// Video-input receiver: tracks hsync/vsync timing and writes the active region into frame memory
// at a running address, flagging frame completion, lock and timing errors.
module vga_capture #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned H_BP     = 47,
  parameter int unsigned V_BP     = 32
) (
  input  logic         clk,
  input  logic         rst,
  vga_capture_if.slave bus
);

  localparam logic [11:0] HActW  = 12'(H_ACTIVE);
  localparam logic [11:0] HBpW   = 12'(H_BP);
  localparam logic [11:0] HEndW  = 12'(H_BP + H_ACTIVE);
  localparam logic [11:0] VLastW = 12'(V_ACTIVE - 1);
  localparam logic [11:0] VBpW   = 12'(V_BP);

  typedef enum logic [1:0] {StWaitVs, StVbp, StActive} state_e;

  state_e      state_q, state_d;
  logic        hs_q, hs_d, vs_q, vs_d;
  logic [11:0] x_q, x_d, ycnt_q, ycnt_d, line_q, line_d, col_q, col_d;
  logic [18:0] wa_q, wa_d;
  logic [18:0] addr_q, addr_d;
  logic [23:0] data_q, data_d;
  logic        wren_q, wren_d, fd_q, fd_d, locked_q, locked_d, err_q, err_d;

  logic        hs_rise, vs_rise, start, bad;
  logic [11:0] x_inc;

  always_comb begin
    state_d  = state_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    x_d      = x_q;
    ycnt_d   = ycnt_q;
    line_d   = line_q;
    col_d    = col_q;
    wa_d     = wa_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wren_d   = 1'b0;
    fd_d     = 1'b0;
    locked_d = locked_q;
    err_d    = 1'b0;
    start    = 1'b0;
    bad      = 1'b0;
    hs_rise  = bus.hsync & ~hs_q;
    vs_rise  = bus.vsync & ~vs_q;
    x_inc    = (x_q == 12'hfff) ? x_q : x_q + 12'd1;

    if (bus.pix_en) begin
      hs_d = bus.hsync;
      vs_d = bus.vsync;
      unique case (state_q)
        StWaitVs: begin
          if (vs_rise) start = 1'b1;
        end
        StVbp: begin
          if (vs_rise) begin
            bad = 1'b1;
          end else if (hs_rise) begin
            ycnt_d = ycnt_q + 12'd1;
            if (ycnt_q + 12'd1 == VBpW) begin
              x_d     = '0;
              col_d   = '0;
              state_d = StActive;
            end
          end
        end
        StActive: begin
          if (vs_rise) begin
            bad = 1'b1;
          end else if (hs_rise) begin
            if (col_q == HActW) begin
              line_d = line_q + 12'd1;
              x_d    = '0;
              col_d  = '0;
            end else begin
              bad = 1'b1;
            end
          end else begin
            x_d = x_inc;
            if (x_inc >= HBpW && x_inc < HEndW) begin
              addr_d = wa_q;
              data_d = bus.din;
              wren_d = 1'b1;
              wa_d   = wa_q + 19'd1;
              col_d  = col_q + 12'd1;
              if (line_q == VLastW && col_q + 12'd1 == HActW) begin
                fd_d     = 1'b1;
                locked_d = 1'b1;
                state_d  = StWaitVs;
              end
            end
          end
        end
        default: state_d = StWaitVs;
      endcase
    end

    // A timing error doubles as the start of the next frame.
    if (bad) begin
      err_d    = 1'b1;
      locked_d = 1'b0;
      start    = 1'b1;
    end
    if (start) begin
      ycnt_d  = '0;
      wa_d    = '0;
      line_d  = '0;
      state_d = StVbp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StWaitVs;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      x_q      <= '0;
      ycnt_q   <= '0;
      line_q   <= '0;
      col_q    <= '0;
      wa_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wren_q   <= 1'b0;
      fd_q     <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      x_q      <= x_d;
      ycnt_q   <= ycnt_d;
      line_q   <= line_d;
      col_q    <= col_d;
      wa_q     <= wa_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wren_q   <= wren_d;
      fd_q     <= fd_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign bus.addr       = addr_q;
  assign bus.data       = data_q;
  assign bus.wren       = wren_q;
  assign bus.frame_done = fd_q;
  assign bus.locked     = locked_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture: a reduced-size instance (8x4, H_BP=3, V_BP=2) and an instance
// with full 800-pixel line timing but only 2 active lines.
module tb_vga_capture;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_capture_if sif ();
  vga_capture_if fif ();

  vga_capture #(.H_ACTIVE(8), .V_ACTIVE(4), .H_BP(3), .V_BP(2)) u_small (
    .clk(clk), .rst(rst), .bus(sif)
  );
  vga_capture #(.V_ACTIVE(2), .V_BP(2)) u_full (
    .clk(clk), .rst(rst), .bus(fif)
  );

  int checks = 0;
  int errors = 0;
  int gap = 1;

  logic [18:0] wa_log[$];
  logic [23:0] wd_log[$];
  int fd_cnt, err_cnt, lat_bad, fd_bad;
  logic [18:0] fd_addr;
  logic pe_at_edge;

  int f_cnt, f_fd_cnt, f_err_cnt;
  logic [18:0] f_first_a, f_last_a, f_fd_addr;
  logic [23:0] f_first_d, f_last_d;

  always @(posedge clk) pe_at_edge <= sif.pix_en;

  always @(negedge clk) begin
    if (sif.wren) begin
      wa_log.push_back(sif.addr);
      wd_log.push_back(sif.data);
      if (pe_at_edge !== 1'b1) lat_bad++;
    end
    if (sif.frame_done) begin
      fd_cnt++;
      fd_addr = sif.addr;
      if (!sif.wren) fd_bad++;
    end
    if (sif.err) err_cnt++;
    if (fif.wren) begin
      if (f_cnt == 0) begin
        f_first_a = fif.addr;
        f_first_d = fif.data;
      end
      f_last_a = fif.addr;
      f_last_d = fif.data;
      f_cnt++;
    end
    if (fif.frame_done) begin
      f_fd_cnt++;
      f_fd_addr = fif.addr;
    end
    if (fif.err) f_err_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    idle(2);
    wa_log.delete();
    wd_log.delete();
    fd_cnt = 0;
    err_cnt = 0;
    lat_bad = 0;
    fd_bad = 0;
  endtask

  // One pix_en strobe, then gap-1 idle cycles; always entered and left on a negedge.
  task automatic drive(input logic hs, input logic vs, input logic [23:0] d);
    sif.pix_en = 1'b1;
    sif.hsync  = hs;
    sif.vsync  = vs;
    sif.din    = d;
    @(negedge clk);
    sif.pix_en = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  // Two low samples, the rising-edge sample, then two back-porch samples.
  task automatic hsync_pulse();
    drive(1'b0, 1'b1, 24'd0);
    drive(1'b0, 1'b1, 24'd0);
    drive(1'b1, 1'b1, 24'd0);
    drive(1'b1, 1'b1, 24'd0);
    drive(1'b1, 1'b1, 24'd0);
  endtask

  task automatic vsync_pulse();
    drive(1'b1, 1'b0, 24'd0);
    drive(1'b1, 1'b0, 24'd0);
    drive(1'b1, 1'b1, 24'd0);
  endtask

  task automatic active_line(input int ln, input int npix);
    for (int c = 0; c < npix; c++) drive(1'b1, 1'b1, 24'(ln * 16 + c));
    drive(1'b1, 1'b1, 24'd0);
  endtask

  task automatic active_frame();
    for (int l = 0; l < 4; l++) begin
      active_line(l, 8);
      if (l < 3) hsync_pulse();
    end
    hsync_pulse();
  endtask

  task automatic frame_body(input bit skip_vs);
    if (!skip_vs) vsync_pulse();
    hsync_pulse();
    hsync_pulse();
    active_frame();
    idle(2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    if ({sif.addr, sif.data, sif.wren, sif.frame_done, sif.locked, sif.err} !== '0) begin
      errors++;
      $display("FAIL reset_small got addr=%0d data=%0d wren=%b fd=%b lk=%b err=%b want all 0",
               sif.addr, sif.data, sif.wren, sif.frame_done, sif.locked, sif.err);
    end
    checks++;
    if ({fif.addr, fif.data, fif.wren, fif.frame_done, fif.locked, fif.err} !== '0) begin
      errors++;
      $display("FAIL reset_full got addr=%0d data=%0d wren=%b want all 0",
               fif.addr, fif.data, fif.wren);
    end
    checks++;
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_clean_frame(input int g, input string tag);
    gap = g;
    clear_log();
    frame_body(1'b0);
    if (wa_log.size() != 32) begin
      errors++;
      $display("FAIL %s_count got=%0d want=32", tag, wa_log.size());
    end
    checks++;
    for (int i = 0; i < wa_log.size() && i < 32; i++) begin
      if (wa_log[i] !== 19'(i) || wd_log[i] !== 24'((i / 8) * 16 + i % 8)) begin
        errors++;
        $display("FAIL %s_write[%0d] got a=%0d d=%0d want a=%0d d=%0d", tag, i, wa_log[i],
                 wd_log[i], i, (i / 8) * 16 + i % 8);
      end
      checks++;
    end
    if (fd_cnt != 1 || fd_addr !== 19'd31 || fd_bad != 0) begin
      errors++;
      $display("FAIL %s_frame_done got n=%0d a=%0d lone=%0d want n=1 a=31 lone=0", tag, fd_cnt,
               fd_addr, fd_bad);
    end
    checks++;
    if (sif.locked !== 1'b1 || err_cnt != 0) begin
      errors++;
      $display("FAIL %s_lock got locked=%b errs=%0d want 1 0", tag, sif.locked, err_cnt);
    end
    checks++;
    if (lat_bad != 0) begin
      errors++;
      $display("FAIL %s_latency got late=%0d want 0", tag, lat_bad);
    end
    checks++;
  endtask

  // Shared tail: a recovery frame after an error starts at address 0 and completes.
  task automatic check_recovery(input string tag);
    clear_log();
    frame_body(1'b1);
    if (wa_log.size() != 32 || wa_log[0] !== 19'd0 || wa_log[31] !== 19'd31) begin
      errors++;
      $display("FAIL %s_recover got n=%0d first=%0d want n=32 first=0 last=31", tag,
               wa_log.size(), (wa_log.size() > 0) ? wa_log[0] : 19'h7ffff);
    end
    checks++;
    if (fd_cnt != 1 || err_cnt != 0 || sif.locked !== 1'b1) begin
      errors++;
      $display("FAIL %s_recover_status got fd=%0d err=%0d lk=%b want 1 0 1", tag, fd_cnt,
               err_cnt, sif.locked);
    end
    checks++;
  endtask

  task automatic test_short_line();
    gap = 1;
    clear_log();
    vsync_pulse();
    hsync_pulse();
    hsync_pulse();
    active_line(0, 8);
    hsync_pulse();
    active_line(1, 8);
    hsync_pulse();
    for (int c = 0; c < 4; c++) drive(1'b1, 1'b1, 24'(32 + c));
    drive(1'b0, 1'b1, 24'd36);
    drive(1'b1, 1'b1, 24'd0);
    drive(1'b1, 1'b1, 24'd0);
    drive(1'b1, 1'b1, 24'd0);
    idle(2);
    if (err_cnt != 1 || sif.locked !== 1'b0 || fd_cnt != 0) begin
      errors++;
      $display("FAIL short_line got err=%0d lk=%b fd=%0d want 1 0 0", err_cnt, sif.locked,
               fd_cnt);
    end
    checks++;
    if (wa_log.size() != 21) begin
      errors++;
      $display("FAIL short_line_writes got=%0d want=21", wa_log.size());
    end
    checks++;
    check_recovery("short_line");
  endtask

  task automatic test_vsync_mid();
    gap = 1;
    clear_log();
    vsync_pulse();
    hsync_pulse();
    hsync_pulse();
    active_line(0, 8);
    hsync_pulse();
    drive(1'b1, 1'b1, 24'd16);
    drive(1'b1, 1'b1, 24'd17);
    drive(1'b1, 1'b0, 24'd18);
    drive(1'b1, 1'b1, 24'd0);
    idle(2);
    if (err_cnt != 1 || sif.locked !== 1'b0 || wa_log.size() != 11) begin
      errors++;
      $display("FAIL vsync_mid got err=%0d lk=%b n=%0d want 1 0 11", err_cnt, sif.locked,
               wa_log.size());
    end
    checks++;
    check_recovery("vsync_mid");
  endtask

  task automatic test_simultaneous();
    gap = 1;
    clear_log();
    vsync_pulse();
    hsync_pulse();
    drive(1'b0, 1'b0, 24'd0);
    drive(1'b0, 1'b0, 24'd0);
    drive(1'b1, 1'b1, 24'd0);
    drive(1'b1, 1'b1, 24'd0);
    hsync_pulse();
    active_line(0, 8);
    idle(2);
    if (err_cnt != 1 || sif.locked !== 1'b0) begin
      errors++;
      $display("FAIL simul_err got err=%0d lk=%b want 1 0", err_cnt, sif.locked);
    end
    checks++;
    if (wa_log.size() != 0) begin
      errors++;
      $display("FAIL simul_ycnt got writes=%0d want=0", wa_log.size());
    end
    checks++;
    clear_log();
    hsync_pulse();
    active_frame();
    idle(2);
    if (wa_log.size() != 32 || wa_log[0] !== 19'd0 || fd_cnt != 1 || fd_addr !== 19'd31) begin
      errors++;
      $display("FAIL simul_frame got n=%0d fd=%0d fda=%0d want 32 1 31", wa_log.size(),
               fd_cnt, fd_addr);
    end
    checks++;
  endtask

  task automatic test_rst_mid();
    gap = 1;
    clear_log();
    vsync_pulse();
    hsync_pulse();
    hsync_pulse();
    active_line(0, 8);
    hsync_pulse();
    active_line(1, 8);
    hsync_pulse();
    active_line(2, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if ({sif.addr, sif.data, sif.wren, sif.frame_done, sif.locked, sif.err} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs got addr=%0d data=%0d wren=%b fd=%b lk=%b err=%b want 0",
               sif.addr, sif.data, sif.wren, sif.frame_done, sif.locked, sif.err);
    end
    checks++;
    clear_log();
    active_line(2, 4);
    hsync_pulse();
    active_line(3, 8);
    hsync_pulse();
    hsync_pulse();
    hsync_pulse();
    idle(2);
    if (wa_log.size() != 0 || err_cnt != 0 || fd_cnt != 0) begin
      errors++;
      $display("FAIL rst_mid_idle got n=%0d err=%0d fd=%0d want 0 0 0", wa_log.size(), err_cnt,
               fd_cnt);
    end
    checks++;
    clear_log();
    frame_body(1'b0);
    if (wa_log.size() != 32 || wa_log[0] !== 19'd0 || fd_cnt != 1 || sif.locked !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_restart got n=%0d fd=%0d lk=%b want 32 1 1", wa_log.size(),
               fd_cnt, sif.locked);
    end
    checks++;
  endtask

  // 800-pixel lines, hsync low for pixels 657..752, vsync low on source lines 0-1, pix_en every
  // 2nd clock. Active lines are source lines 4 and 5.
  task automatic test_full_timing();
    f_cnt = 0;
    f_fd_cnt = 0;
    f_err_cnt = 0;
    for (int l = 0; l < 6; l++) begin
      for (int p = 0; p < 800; p++) begin
        fif.pix_en = 1'b1;
        fif.hsync  = !(p >= 657 && p <= 752);
        fif.vsync  = (l >= 2);
        fif.din    = {12'(l), 12'(p)};
        @(negedge clk);
        fif.pix_en = 1'b0;
        @(negedge clk);
      end
    end
    idle(2);
    if (f_cnt != 1280) begin
      errors++;
      $display("FAIL full_count got=%0d want=1280", f_cnt);
    end
    checks++;
    if (f_first_a !== 19'd0 || f_first_d !== {12'd4, 12'd0}) begin
      errors++;
      $display("FAIL full_first got a=%0d d=%h want a=0 d=%h", f_first_a, f_first_d,
               {12'd4, 12'd0});
    end
    checks++;
    if (f_last_a !== 19'd1279 || f_last_d !== {12'd5, 12'd639}) begin
      errors++;
      $display("FAIL full_last got a=%0d d=%h want a=1279 d=%h", f_last_a, f_last_d,
               {12'd5, 12'd639});
    end
    checks++;
    if (f_fd_cnt != 1 || f_fd_addr !== 19'd1279 || f_err_cnt != 0 || fif.locked !== 1'b1) begin
      errors++;
      $display("FAIL full_done got fd=%0d a=%0d err=%0d lk=%b want 1 1279 0 1", f_fd_cnt,
               f_fd_addr, f_err_cnt, fif.locked);
    end
    checks++;
  endtask

  initial begin
    rst = 1'b1;
    sif.pix_en = 1'b0;
    sif.hsync  = 1'b1;
    sif.vsync  = 1'b1;
    sif.din    = '0;
    fif.pix_en = 1'b0;
    fif.hsync  = 1'b1;
    fif.vsync  = 1'b1;
    fif.din    = '0;
    @(negedge clk);
    test_reset();
    test_clean_frame(1, "clean");
    test_clean_frame(3, "stride3");
    test_short_line();
    test_vsync_mid();
    test_simultaneous();
    test_rst_mid();
    test_full_timing();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_capture.md
# vga_capture

Video-input receiver: samples an active-low hsync/vsync, 24-bit RGB pixel stream at one pixel per `pix_en` strobe and writes the active 640x480 region into the 19-bit frame memory, one word per pixel at address `line*H_ACTIVE + col`. It is the write-side counterpart of the VGA output controller, which reads the same memory. It also reports frame completion, lock and timing errors.

## Interface
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `H_BP`, 47: pixel strobes from the hsync rising-edge sample to the first active pixel.
- `V_BP`, 32: hsync rising edges after the vsync rising edge before the first active line.
- `clk` in 1: the single clock; all logic on posedge.
- `rst` in 1: reset. Synchronous and active-high.
- `pix_en` in 1: pixel strobe. Inputs are sampled only in cycles where it is high.
- `hsync` in 1: horizontal sync, active low.
- `vsync` in 1: vertical sync, active low.
- `din` in 24: pixel RGB.
- `addr` out 19: frame-memory write address.
- `data` out 24: frame-memory write data.
- `wren` out 1: write enable, one-cycle pulse per pixel.
- `frame_done` out 1: one-cycle pulse on the last pixel write of a frame.
- `locked` out 1: high after one clean frame; cleared on error.
- `err` out 1: one-cycle pulse on a timing violation.

## Operation
- Sampling and edge detection:
  - Sync values from the previous sample are held in `hs_q` and `vs_q`. Reset value of both is 1.
  - Rising edge is detected on a `pix_en` sample when the current value is 1 and the previous sample is 0.
- Counters:
  - `x`: 12-bit pixel counter.
  - `ycnt`: 12-bit count of hsync edges during back porch.
  - `line`: 12-bit active-line counter.
  - `col`: 12-bit pixels written in the current line.
  - `wa`: 19-bit running write address. It increments per write, so no multiplier is needed.
- States:
  - WAIT_VS: idle or post-frame.
    - vsync rising edge: `ycnt`=0, `wa`=0, `line`=0, go to V_BP.
    - hsync edges are ignored.
  - V_BP:
    - Each hsync rising edge increments `ycnt`.
    - The edge that makes `ycnt`==V_BP sets `x`=0 and `col`=0, and goes to ACTIVE.
  - ACTIVE:
    - Each `pix_en` increments `x`. `x` saturates at 4095.
    - Pixel-write window: `H_BP` <= `x`(after increment) < `H_BP`+`H_ACTIVE`.
      - Register `addr`=`wa`, `data`=`din` and pulse `wren`.
      - Then `wa`++ and `col`++.
    - hsync rising edge:
      - If `col`==`H_ACTIVE`: `line`++, `x`=0, `col`=0.
      - Otherwise: short line, treated as an error.
    - Write with `line`==`V_ACTIVE`-1 and `col` reaching `H_ACTIVE` (address `H_ACTIVE*V_ACTIVE`-1, i.e. 307199):
      - Pulse `frame_done` with that write.
      - Set `locked`.
      - Go to WAIT_VS.
- Error handling. Either of the following pulses `err`, clears `locked`, and treats the sample as a new frame start (`ycnt`=0, `wa`=0, `line`=0, state V_BP):
  - vsync rising edge in V_BP or ACTIVE (short frame).
  - Short line, as defined under ACTIVE.
- Simultaneous hsync and vsync rising edges on one sample: vsync wins and the hsync edge is ignored.
- Samples taken while `pix_en`=0 are ignored entirely. Counters and edge registers hold.

## Timing
- Reset values: `addr`=0, `data`=0, `wren`=0, `frame_done`=0, `locked`=0, `err`=0, state WAIT_VS, all counters 0.
- `rst` mid-frame aborts the frame. No `err` or `frame_done` pulse is produced.
- Latency: `wren`, `addr` and `data` are valid in the cycle after the `pix_en` sample that carried the pixel. They hold until the next write. `wren` is high for exactly 1 cycle.
- `frame_done` is coincident with the final `wren`.
- `err` is asserted the cycle after the offending sample.
- `locked` rises together with `frame_done` and falls together with `err`.
- With the default parameters and 800x525 source timing (hsync low for pixels 657–752, vsync low for lines 491–492, `pix_en` every 2nd clk):
  - Source pixel 0 of line 0 lands at address 0.
  - Source pixel 639 of line 479 lands at address 307199.

## Test plan
- Reduced parameters (H_ACTIVE=8, V_ACTIVE=4, H_BP=3, V_BP=2), clean frame with `din`=line*16+col, `pix_en` every cycle:
  - Exactly 32 writes to addresses 0..31 with matching data.
  - `frame_done` on the write to address 31, then `locked`=1.
  - `err` never asserted.
- Same frame with `pix_en` every 3rd cycle: identical write sequence; each `wren` comes 1 clk after its strobe.
- Hsync rising edge after only 5 pixels of line 2:
  - `err` pulses once and `locked` clears.
  - No `frame_done`.
  - Next clean frame restarts at address 0.
- Vsync rising edge during line 1 of ACTIVE: `err` pulses; frame restarts at address 0 and completes normally after V_BP lines.
- Hsync and vsync rising edges on the same sample in V_BP: `ycnt` resets to 0 and the hsync edge is not counted.
- `rst` asserted for 1 cycle mid-line 2:
  - All outputs are 0 the next cycle and state is WAIT_VS.
  - Captured writes start again only after the next vsync rising edge.
- Full-size defaults with 800x525 source timing: first write at address 0, last at address 307199 with `frame_done`.
